// File: rtl/nibble_add_sequencer.sv
//-----------------------------------------------------------------------------
// nibble_add_sequencer
//
// Shares one external 4-bit ripple-carry adder between two requesters.
// A wide addition of 4*NIBBLES bits is performed one nibble per cycle,
// least-significant nibble first. The carry between nibbles is held in a
// register. Requests are arbitrated round-robin and the result is returned
// on a single response channel tagged with the requester id.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   req0_* / req1_*            valid/ready request channels (a, b, cin)
//   resp_*                     valid/ready response channel (sum, cout, id)
//   busy                       high while an operation is in CALC or DONE
//   add_a, add_b, add_cin      operands driven to the external adder
//   add_sum, add_cout          combinational result from the external adder
//-----------------------------------------------------------------------------
module nibble_add_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic [4*NIBBLES-1:0]   req0_a,
    input  logic [4*NIBBLES-1:0]   req0_b,
    input  logic                   req0_cin,

    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic [4*NIBBLES-1:0]   req1_a,
    input  logic [4*NIBBLES-1:0]   req1_b,
    input  logic                   req1_cin,

    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [4*NIBBLES-1:0]   resp_sum,
    output logic                   resp_cout,
    output logic                   resp_id,

    output logic                   busy,

    output logic [3:0]             add_a,
    output logic [3:0]             add_b,
    output logic                   add_cin,
    input  logic [3:0]             add_sum,
    input  logic                   add_cout
);

    // Counter needs at least one bit even for a single-nibble configuration.
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    state;
    logic [CW-1:0]             cnt;

    // Operands and the partial result are stored as nibble arrays so the
    // active slice is a plain index by the counter.
    logic [NIBBLES-1:0][3:0]   opa;
    logic [NIBBLES-1:0][3:0]   opb;
    logic [NIBBLES-1:0][3:0]   result;
    logic [NIBBLES-1:0][3:0]   result_nxt;

    // Response registers are separate from the working result so that the
    // last response stays visible while the next operation is computed.
    logic [NIBBLES-1:0][3:0]   sum_q;
    logic                      cout_q;
    logic                      id_q;

    logic                      carry;
    logic                      cur_id;
    logic                      last_grant;

    logic                      grant0;
    logic                      grant1;
    logic                      in_calc;

    //-------------------------------------------------------------------------
    // Round-robin arbitration: on contention the requester that was not
    // served last wins. last_grant resets to 1 so requester 0 wins first.
    //-------------------------------------------------------------------------
    always_comb begin
        grant0 = req0_valid && (!req1_valid || last_grant);
        grant1 = req1_valid && (!req0_valid || !last_grant);
    end

    // Ready is gated by reset so nothing is accepted while rst is asserted.
    assign req0_ready = !rst && (state == IDLE) && grant0;
    assign req1_ready = !rst && (state == IDLE) && grant1;

    //-------------------------------------------------------------------------
    // Result with the current adder nibble merged in. Used both for the
    // working register and for the response register on the last nibble,
    // so the final nibble does not need an extra cycle.
    //-------------------------------------------------------------------------
    always_comb begin
        result_nxt      = result;
        result_nxt[cnt] = add_sum;
    end

    //-------------------------------------------------------------------------
    // Control FSM and datapath registers
    //-------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            opa        <= '0;
            opb        <= '0;
            result     <= '0;
            sum_q      <= '0;
            cout_q     <= 1'b0;
            id_q       <= 1'b0;
            carry      <= 1'b0;
            cur_id     <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req0_ready || req1_ready) begin
                        // At most one ready is high, so req1_ready alone
                        // selects the winner.
                        opa        <= req1_ready ? req1_a   : req0_a;
                        opb        <= req1_ready ? req1_b   : req0_b;
                        carry      <= req1_ready ? req1_cin : req0_cin;
                        cur_id     <= req1_ready;
                        last_grant <= req1_ready;
                        cnt        <= '0;
                        state      <= CALC;
                    end
                end

                CALC: begin
                    result <= result_nxt;
                    carry  <= add_cout;
                    if (cnt == LAST) begin
                        sum_q  <= result_nxt;
                        cout_q <= add_cout;
                        id_q   <= cur_id;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DONE: begin
                    if (resp_ready) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    //-------------------------------------------------------------------------
    // Outputs. Every output is forced low while rst is asserted, so the
    // first reset cycle already presents a clean interface even if the
    // sequencer was mid-operation.
    //-------------------------------------------------------------------------
    assign in_calc    = !rst && (state == CALC);

    assign add_a      = in_calc ? opa[cnt] : 4'h0;
    assign add_b      = in_calc ? opb[cnt] : 4'h0;
    assign add_cin    = in_calc && carry;

    assign resp_valid = !rst && (state == DONE);
    assign busy       = !rst && (state != IDLE);
    assign resp_sum   = rst ? '0 : sum_q;
    assign resp_cout  = !rst && cout_q;
    assign resp_id    = !rst && id_q;

endmodule

// File: tb/tb_nibble_add_sequencer.sv
module tb_nibble_add_sequencer;
  localparam int N = 4;
  localparam int W = 4 * N;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Main DUT (NIBBLES = 4)
  logic         req0_valid, req0_ready, req0_cin;
  logic         req1_valid, req1_ready, req1_cin;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         resp_valid, resp_ready, resp_cout, resp_id, busy;
  logic [W-1:0] resp_sum;
  logic [3:0]   add_a, add_b, add_sum;
  logic         add_cin, add_cout;

  assign {add_cout, add_sum} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

  nibble_add_sequencer #(.NIBBLES(N)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_sum(resp_sum), .resp_cout(resp_cout), .resp_id(resp_id),
    .busy(busy),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout)
  );

  // Second DUT (NIBBLES = 1)
  logic       s_req0_valid, s_req0_ready, s_req0_cin;
  logic       s_req1_valid, s_req1_ready, s_req1_cin;
  logic [3:0] s_req0_a, s_req0_b, s_req1_a, s_req1_b;
  logic       s_resp_valid, s_resp_ready, s_resp_cout, s_resp_id, s_busy;
  logic [3:0] s_resp_sum;
  logic [3:0] s_add_a, s_add_b, s_add_sum;
  logic       s_add_cin, s_add_cout;

  assign {s_add_cout, s_add_sum} = 5'(s_add_a) + 5'(s_add_b) + 5'(s_add_cin);

  nibble_add_sequencer #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst(rst),
    .req0_valid(s_req0_valid), .req0_ready(s_req0_ready), .req0_a(s_req0_a), .req0_b(s_req0_b), .req0_cin(s_req0_cin),
    .req1_valid(s_req1_valid), .req1_ready(s_req1_ready), .req1_a(s_req1_a), .req1_b(s_req1_b), .req1_cin(s_req1_cin),
    .resp_valid(s_resp_valid), .resp_ready(s_resp_ready), .resp_sum(s_resp_sum), .resp_cout(s_resp_cout), .resp_id(s_resp_id),
    .busy(s_busy),
    .add_a(s_add_a), .add_b(s_add_b), .add_cin(s_add_cin), .add_sum(s_add_sum), .add_cout(s_add_cout)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: plain arithmetic on whole operands.
  typedef struct {
    logic         id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
  } op_t;

  op_t  exp_q[$];
  logic acc_log[$];

  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    return {1'b0, a} + {1'b0, b} + (W+1)'(cin);
  endfunction

  function automatic logic [3:0] nib(input logic [W-1:0] x, input int k);
    longint unsigned v;
    v = longint'(x);
    return 4'((v >> (4 * k)) & 64'hF);
  endfunction

  // Carry entering nibble k = carry out of the low k nibbles of a+b+cin.
  function automatic logic cin_at(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input int k);
    longint unsigned mask, s;
    if (k == 0) return cin;
    mask = (64'd1 << (4 * k)) - 64'd1;
    s = (longint'(a) & mask) + (longint'(b) & mask) + longint'(cin);
    return 1'((s >> (4 * k)) & 64'd1);
  endfunction

  // Monitor / scoreboard
  op_t          cur;
  op_t          popped;
  bit           inflight = 1'b0;
  int           age = 0;
  int           mk;
  bit           hold_v = 1'b0;
  logic [W-1:0] hold_sum;
  logic         hold_cout, hold_id;
  logic [W:0]   r;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      inflight = 1'b0;
      hold_v   = 1'b0;
    end else begin
      if (req0_valid && req1_valid) check("ready_onehot", 64'(req0_ready & req1_ready), 64'd0);
      if (busy) begin
        check("ready0_busy", 64'(req0_ready), 64'd0);
        check("ready1_busy", 64'(req1_ready), 64'd0);
      end

      if (inflight) begin
        age++;
        if (age <= N) begin
          mk = age - 1;
          check("add_a", 64'(add_a), 64'(nib(cur.a, mk)));
          check("add_b", 64'(add_b), 64'(nib(cur.b, mk)));
          check("add_cin", 64'(add_cin), 64'(cin_at(cur.a, cur.b, cur.cin, mk)));
          check("calc_busy", 64'(busy), 64'd1);
          check("calc_no_valid", 64'(resp_valid), 64'd0);
        end else if (age == N + 1) begin
          check("latency", 64'(resp_valid), 64'd1);
        end
      end

      if (resp_valid && !resp_ready) begin
        if (hold_v) begin
          check("hold_sum", 64'(resp_sum), 64'(hold_sum));
          check("hold_cout", 64'(resp_cout), 64'(hold_cout));
          check("hold_id", 64'(resp_id), 64'(hold_id));
        end
        hold_v    = 1'b1;
        hold_sum  = resp_sum;
        hold_cout = resp_cout;
        hold_id   = resp_id;
      end else begin
        hold_v = 1'b0;
      end

      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp", 64'd1, 64'd0);
        end else begin
          popped = exp_q.pop_front();
          r = ref_add(popped.a, popped.b, popped.cin);
          check("sum", 64'(resp_sum), 64'(r[W-1:0]));
          check("cout", 64'(resp_cout), 64'(r[W]));
          check("id", 64'(resp_id), 64'(popped.id));
        end
        inflight = 1'b0;
      end

      if (req0_valid && req0_ready) begin
        cur = '{id: 1'b0, a: req0_a, b: req0_b, cin: req0_cin};
        exp_q.push_back(cur);
        acc_log.push_back(1'b0);
        inflight = 1'b1;
        age = 0;
      end else if (req1_valid && req1_ready) begin
        cur = '{id: 1'b1, a: req1_a, b: req1_b, cin: req1_cin};
        exp_q.push_back(cur);
        acc_log.push_back(1'b1);
        inflight = 1'b1;
        age = 0;
      end
    end
  end

  // Drive one request and hold it until accepted (bounded).
  task automatic issue(input logic id, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    bit found;
    found = 1'b0;
    if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cin = cin; end
    else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cin = cin; end
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) found = 1'b1;
    end
    check("accept_timeout", 64'(found), 64'd1);
    @(posedge clk); #1;
    if (id) req1_valid = 1'b0;
    else    req0_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    check("done_timeout", 64'(done), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_req0_ready"}, 64'(req0_ready), 64'd0);
    check({tag, "_req1_ready"}, 64'(req1_ready), 64'd0);
    check({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
    check({tag, "_resp_sum"},   64'(resp_sum),   64'd0);
    check({tag, "_resp_cout"},  64'(resp_cout),  64'd0);
    check({tag, "_resp_id"},    64'(resp_id),    64'd0);
    check({tag, "_busy"},       64'(busy),       64'd0);
    check({tag, "_add_a"},      64'(add_a),      64'd0);
    check({tag, "_add_b"},      64'(add_b),      64'd0);
    check({tag, "_add_cin"},    64'(add_cin),    64'd0);
  endtask

  task automatic drv(input logic id, input int nops);
    for (int i = 0; i < nops; i++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      issue(id, W'($urandom), W'($urandom), 1'($urandom));
    end
  endtask

  bit         rand_done;
  bit         h0, h1, found1, got1;
  int         lat;
  logic [4:0] sref;

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
    resp_ready = 1'b1;
    s_req0_valid = 1'b0; s_req0_a = '0; s_req0_b = '0; s_req0_cin = 1'b0;
    s_req1_valid = 1'b0; s_req1_a = '0; s_req1_b = '0; s_req1_cin = 1'b0;
    s_resp_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_zero("in_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_zero("post_rst");
    @(posedge clk); #1;

    // Directed additions
    issue(1'b0, 16'h1234, 16'h0FFF, 1'b0);
    wait_done();
    issue(1'b1, 16'hFFFF, 16'h0001, 1'b0);
    wait_done();
    issue(1'b1, 16'hFFFF, 16'h0000, 1'b1);
    wait_done();

    // Contention from reset: both valid continuously
    acc_log.delete();
    rst = 1'b1;
    req0_valid = 1'b1; req0_a = 16'h1111; req0_b = 16'h2222; req0_cin = 1'b0;
    req1_valid = 1'b1; req1_a = 16'h3333; req1_b = 16'h4444; req1_cin = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 200 && acc_log.size() < 4; i++) begin
      @(negedge clk);
      h0 = req0_ready;
      h1 = req1_ready;
      @(posedge clk); #1;
      if (h0) begin req0_a = W'($urandom); req0_b = W'($urandom); req0_cin = 1'($urandom); end
      if (h1) begin req1_a = W'($urandom); req1_b = W'($urandom); req1_cin = 1'($urandom); end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("contention_count", 64'(acc_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < acc_log.size(); i++)
      check($sformatf("order_%0d", i), 64'(acc_log[i]), 64'(i % 2));
    wait_done();

    // Backpressure
    resp_ready = 1'b0;
    issue(1'b0, 16'hA5A5, 16'h5A5B, 1'b1);
    found1 = 1'b0;
    for (int i = 0; i < 20 && !found1; i++) begin
      @(negedge clk);
      if (resp_valid) found1 = 1'b1;
    end
    check("bp_valid_seen", 64'(found1), 64'd1);
    @(posedge clk); #1;
    req1_valid = 1'b1; req1_a = 16'h0F0F; req1_b = 16'h00F1; req1_cin = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("bp_valid_held", 64'(resp_valid), 64'd1);
      check("bp_no_ready1", 64'(req1_ready), 64'd0);
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 64'(resp_valid), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_next_accept", 64'(req1_ready), 64'd1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    wait_done();

    // Reset while in CALC at cnt = 2
    issue(1'b1, 16'h7777, 16'h8889, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_zero("abort_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_zero("abort_idle");
    @(posedge clk); #1;
    issue(1'b0, 16'h0001, 16'h0001, 1'b0);
    wait_done();

    // Randomized traffic with random response backpressure
    rand_done = 1'b0;
    fork
      begin
        fork
          drv(1'b0, 15);
          drv(1'b1, 15);
        join
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          resp_ready = ($urandom_range(0, 3) != 0);
        end
        resp_ready = 1'b1;
      end
    join
    wait_done();
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    // NIBBLES = 1 instance
    s_req0_valid = 1'b1; s_req0_a = 4'hF; s_req0_b = 4'h1; s_req0_cin = 1'b1;
    sref = 5'(s_req0_a) + 5'(s_req0_b) + 5'(s_req0_cin);
    found1 = 1'b0;
    for (int i = 0; i < 10 && !found1; i++) begin
      @(negedge clk);
      if (s_req0_ready) found1 = 1'b1;
    end
    check("n1_accept", 64'(found1), 64'd1);
    @(posedge clk); #1;
    s_req0_valid = 1'b0;
    lat = 0;
    got1 = 1'b0;
    for (int i = 0; i < 10 && !got1; i++) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        check("n1_add_a", 64'(s_add_a), 64'h0F);
        check("n1_add_cin", 64'(s_add_cin), 64'd1);
      end
      if (s_resp_valid) got1 = 1'b1;
    end
    check("n1_latency", 64'(lat), 64'd2);
    check("n1_sum", 64'(s_resp_sum), 64'(sref[3:0]));
    check("n1_cout", 64'(s_resp_cout), 64'(sref[4]));
    check("n1_id", 64'(s_resp_id), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("n1_idle", 64'(s_busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/nibble_add_sequencer.md
Name: nibble_add_sequencer

Overview:
Controller that shares one external 4-bit ripple-carry parallel adder between two requesters. It performs wide additions of 4*NIBBLES bits by sequencing the adder one nibble per cycle, least-significant nibble first, and chains the carry through a register. Two requesters are served by a round-robin arbiter using valid/ready handshakes. The result is returned on a single response channel tagged with the requester ID.

Parameters:
NIBBLES, 4, number of 4-bit slices per operation; operand width W = 4*NIBBLES (derived, not overridable); legal range 1..16

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
req0_valid  input  1  requester 0 has an operation pending
req0_ready  output  1  requester 0 operation accepted this cycle
req0_a  input  W  requester 0 operand A
req0_b  input  W  requester 0 operand B
req0_cin  input  1  requester 0 carry-in
req1_valid  input  1  requester 1 has an operation pending
req1_ready  output  1  requester 1 operation accepted this cycle
req1_a  input  W  requester 1 operand A
req1_b  input  W  requester 1 operand B
req1_cin  input  1  requester 1 carry-in
resp_valid  output  1  result available
resp_ready  input  1  consumer accepts result
resp_sum  output  W  sum
resp_cout  output  1  final carry-out
resp_id  output  1  requester that issued the result (0/1)
busy  output  1  high in CALC and DONE
add_a  output  4  to adder a
add_b  output  4  to adder b
add_cin  output  1  to adder cin
add_sum  input  4  from adder sum (combinational)
add_cout  input  1  from adder cout (combinational)

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; cnt=0; operand, result, carry and id registers=0; last_grant=1, so req0 wins the first contention. The following outputs are 0 while in reset and immediately after: req*_ready, resp_valid, resp_sum, resp_cout, resp_id, busy, add_a, add_b, add_cin. Reset mid-operation discards the operation; no response is produced.
- States: IDLE, CALC, DONE.
- IDLE:
  - grant = req0 if only req0_valid; req1 if only req1_valid; if both are valid, the requester != last_grant.
  - reqN_ready = (state==IDLE) && grantN. It is combinational from valid and state, and at most one ready is high per cycle.
  - On handshake: capture a, b, cin and id; last_grant<=id; cnt<=0; go to CALC.
  - add_* driven to 0.
- CALC (exactly NIBBLES cycles):
  - add_a=opa[4*cnt+:4], add_b=opb[4*cnt+:4], add_cin=carry (carry initialised to the captured cin).
  - Each edge: result[4*cnt+:4]<=add_sum; carry<=add_cout; cnt<=cnt+1.
  - When cnt==NIBBLES-1: final carry goes to resp_cout; go to DONE.
  - Inputs are ignored; req*_ready=0.
- DONE:
  - resp_valid=1; resp_sum, resp_cout and resp_id are held stable until resp_valid&&resp_ready, then go to IDLE.
  - resp_valid never drops without a handshake.
  - resp_sum, resp_cout and resp_id retain their last values after the handshake.
- Latency: handshake at edge T puts CALC at T..T+NIBBLES-1, and resp_valid is high after edge T+NIBBLES. Minimum initiation interval is NIBBLES+2 cycles (no accept during DONE).
- Arithmetic: {resp_cout,resp_sum} = a + b + cin, modulo 2^(W+1); unsigned.
- Requesters must hold operands stable while valid&&!ready; a valid that drops before ready is simply not served.
- Counter width is clog2(NIBBLES) with a minimum of 1 bit; no wrap beyond NIBBLES-1.

Test Plan:
- req0: a=0x1234, b=0x0FFF, cin=0 -> resp_sum=0x2233, cout=0, id=0; resp_valid exactly 5 cycles after the accept edge. Check add_a sequence 4,3,2,1 and add_b F,F,F,0.
- Full carry ripple: req1: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, id=1. Separately, a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1.
- Contention: both valid continuously after reset with distinct operands -> service order 0,1,0,1. Ready is never high for both; req1_ready=0 while req0 is being served.
- Backpressure: hold resp_ready=0 for 6 cycles after resp_valid -> outputs stable, req*_ready=0, no new accept. Raise resp_ready -> one handshake, return to IDLE, next accept on the following cycle.
- Reset in CALC at cnt=2 -> next cycle all outputs 0 and state IDLE. No response ever appears for the aborted operation. A subsequent request 0x0001+0x0001 -> 0x0002.
- Parameter NIBBLES=1: 0xF+0x1, cin=1 -> sum=0x1, cout=1; resp_valid 2 cycles after accept.
